ram_load_dump_seq: RTL and testbench
====================================

Name: ram_load_dump_seq

Overview:
- Sequencer that sits directly upstream of the single-port RAM (active-low write enable; write and address latch on the falling clock edge; combinational read of the latched address).
- Accepts a valid/ready input stream and writes it to consecutive RAM addresses (LOAD).
- On command, replays the stored words in order onto a valid/ready output stream with backpressure (DUMP).
- Owns every RAM port, so the RAM is never driven by more than one master.

Parameters:
- DATA_WIDTH, 4, word width; must match the RAM.
- ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; RAM shares it.
- rst_n  in  1  reset.
- start_load  in  1  IDLE-only command: begin LOAD at address 0.
- start_dump  in  1  IDLE-only command: begin DUMP of the stored words.
- in_data  in  DATA_WIDTH  load word.
- in_valid  in  1  load word valid.
- in_last  in  1  marks the final word of a load (qualified by in_valid).
- in_ready  out  1  load word accepted this cycle when in_valid.
- out_data  out  DATA_WIDTH  replayed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- count  out  ADDR_WIDTH+1  words stored by the last load (0..DEPTH).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when LOAD or DUMP completes.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we_n  out  1  RAM write enable, active-low.
- ram_q  in  DATA_WIDTH  RAM read data.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: all registers clear.
  - Outputs: state=IDLE, count=0, out_valid=0, out_data=0, done=0, busy=0, in_ready=0.
  - ram_we_n is forced to 1 combinationally while rst_n=0.
  - A reset mid-LOAD leaves the partial RAM contents in place, but count=0.
- States and transitions:
  - IDLE -> LOAD on start_load; load wins if start_load and start_dump arrive together.
  - IDLE -> DUMP on start_dump.
  - Start pulses outside IDLE are ignored.
- LOAD:
  - in_ready=1.
  - ram_we_n = ~in_valid, ram_addr = wr_ptr, ram_data = in_data, all combinational, so the write lands on the falling edge of the handshake cycle.
  - On each handshake, wr_ptr++ and count++.
  - LOAD ends on an in_last handshake, or on the handshake that makes count = DEPTH (auto-terminate; in_last is not required).
  - Termination: -> IDLE, done=1 on the next cycle, in_ready=0 from the next cycle.
  - Entering LOAD sets wr_ptr=0 and count=0.
- DUMP:
  - Entering DUMP sets rd_ptr=0 and remaining=count; ram_addr = rd_ptr (registered); ram_we_n=1.
  - The RAM latches rd_ptr on the falling edge, so ram_q = mem[rd_ptr] at the following rising edge.
  - Capture rule: when remaining>0 and (!out_valid or out_ready), then out_data<=ram_q, out_valid<=1, rd_ptr++, remaining--.
  - A rd_ptr update is visible on ram_q one edge later, so captures are back-to-back at 1 word/cycle.
  - Latency: first out_valid occurs 2 cycles after the start_dump cycle.
  - Backpressure: while out_valid and !out_ready, out_data, rd_ptr and remaining hold.
  - Completion: when remaining=0 and out_valid is consumed, out_valid<=0, go to IDLE, done=1.
  - count=0 at start_dump: DUMP lasts 1 cycle with no out_valid, then done.
- Outside LOAD: ram_we_n=1, ram_data=0.
- Outside DUMP: out_valid=0.
- Arithmetic and widths:
  - wr_ptr wraps to 0 after DEPTH-1, but LOAD always terminates at DEPTH, so no overwrite occurs.
  - count saturates at DEPTH.
  - An empty load (start_load, then no data) stays in LOAD indefinitely.

Optional Feature:
- Macro: LOAD_DUMP_CHECKSUM_EN.
- When defined:
  - Adds port chk_err (out, 1).
  - An XOR accumulator over all words accepted in LOAD is cleared at LOAD entry.
  - A second XOR accumulator over words consumed in DUMP is cleared at DUMP entry.
  - At the DUMP done pulse, chk_err <= (load_xor != dump_xor). The value holds until the next DUMP entry; reset value is 0.
- When undefined: no port and no accumulators.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, DUMP=2'd2), DEPTH derived from ADDR_WIDTH.
- One natural sub-module: ram_load_dump_outreg, the one-entry output register with the valid/ready hold logic.
- The FSM and pointers stay in the top level.

Test Plan:
- Load 5 words 3,7,A,1,F with in_last on the 5th -> 5 RAM writes to addresses 0..4 on falling edges; count=5; done one cycle after the last handshake.
- Dump after that load with out_ready=1 -> out_valid rises 2 cycles after start_dump; out_data 3,7,A,1,F on consecutive cycles; done after F.
- Same dump with out_ready toggling 1,0,0,1,... -> no word lost or duplicated; out_data stable while stalled.
- Load 64 words 0..63 with no in_last -> auto-terminates, count=64, in_ready=0 afterwards; dump returns words 0..63 in order.
- start_dump with count=0 -> done after 1 cycle, out_valid never asserted; start_load and start_dump together -> LOAD entered.
- rst_n=0 mid-DUMP -> next edge: out_valid=0, busy=0, count=0, ram_we_n=1. With LOAD_DUMP_CHECKSUM_EN defined, force a corrupted ram_q on one word -> chk_err=1 at done.

Source files
------------

// File: rtl/ram_load_dump_seq_pkg.sv
// Shared types and constants for the RAM load/dump sequencer.
package ram_load_dump_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   localparam int LP_DATA_WIDTH_DEF = 4;
   localparam int LP_ADDR_WIDTH_DEF = 6;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/ram_load_dump_seq_outreg.sv
// One-entry output register for the dump stream; holds its word while the consumer stalls.
module ram_load_dump_seq_outreg
   import ram_load_dump_seq_pkg::*;
#(
   parameter int DATA_WIDTH = LP_DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_capture,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_take
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end
   end

   // The slot may be refilled when empty or when its word leaves this cycle.
   assign o_take  = !r_valid || i_ready;
   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/ram_load_dump_seq.sv
// Loads a valid/ready stream into the single-port RAM and replays it on command.
// Optional XOR checksum compare of loaded vs. dumped words: LOAD_DUMP_CHECKSUM_EN.
module ram_load_dump_seq
   import ram_load_dump_seq_pkg::*;
#(
   parameter int DATA_WIDTH = LP_DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = LP_ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_load,
   input  logic                  start_dump,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we_n,
`ifdef LOAD_DUMP_CHECKSUM_EN
   output logic                  chk_err,
`endif
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam int                DEPTH       = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] LP_CNT_MAX  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic                  r_done;

   logic w_load;
   logic w_dump;
   logic w_in_hs;
   logic w_load_end;
   logic w_take;
   logic w_capture;
   logic w_dump_end;

   assign w_load     = (r_state == ST_LOAD);
   assign w_dump     = (r_state == ST_DUMP);
   assign w_in_hs    = w_load && in_valid;
   assign w_load_end = w_in_hs && (in_last || (r_count == LP_CNT_LAST));
   assign w_capture  = w_dump && (r_remaining != '0) && w_take;
   assign w_dump_end = w_dump && (r_remaining == '0) && w_take;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_load) begin
                  r_state  <= ST_LOAD;
                  r_wr_ptr <= '0;
                  r_count  <= '0;
               end else if (start_dump) begin
                  r_state     <= ST_DUMP;
                  r_rd_ptr    <= '0;
                  r_remaining <= r_count;
               end
            end
            ST_LOAD: begin
               if (w_in_hs) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (r_count != LP_CNT_MAX)
                     r_count <= r_count + 1'b1;
                  if (w_load_end) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DUMP: begin
               if (w_capture) begin
                  r_rd_ptr    <= r_rd_ptr + 1'b1;
                  r_remaining <= r_remaining - 1'b1;
               end else if (w_dump_end) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   ram_load_dump_seq_outreg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_capture (w_capture),
      .i_flush   (w_dump_end),
      .i_data    (ram_q),
      .i_ready   (out_ready),
      .o_data    (out_data),
      .o_valid   (out_valid),
      .o_take    (w_take)
   );

   // Write strobe is gated by reset directly so a reset mid-load cannot write.
   assign ram_we_n = rst_n ? ~w_in_hs : 1'b1;
   assign ram_addr = w_load ? r_wr_ptr : r_rd_ptr;
   assign ram_data = w_load ? in_data : '0;

   assign in_ready = w_load;
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign count    = r_count;

`ifdef LOAD_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_load_xor;
   logic [DATA_WIDTH-1:0] r_dump_xor;
   logic                  r_chk_err;
   logic                  w_consume;
   logic [DATA_WIDTH-1:0] w_dump_xor_nxt;

   assign w_consume      = w_dump && out_valid && out_ready;
   assign w_dump_xor_nxt = r_dump_xor ^ (w_consume ? out_data : '0);

   // The final word is consumed on the completion edge, so compare against the next value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_load_xor <= '0;
         r_dump_xor <= '0;
         r_chk_err  <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && start_load)
            r_load_xor <= '0;
         else if (w_in_hs)
            r_load_xor <= r_load_xor ^ in_data;

         if ((r_state == ST_IDLE) && !start_load && start_dump) begin
            r_dump_xor <= '0;
            r_chk_err  <= 1'b0;
         end else begin
            if (w_consume)
               r_dump_xor <= w_dump_xor_nxt;
            if (w_dump_end)
               r_chk_err <= (r_load_xor != w_dump_xor_nxt);
         end
      end
   end

   assign chk_err = r_chk_err;
`else
   // Checksum disabled: dumped words are not observed beyond the output register.
`endif

endmodule

// File: tb/tb_ram_load_dump_seq.sv
// Directed bench for ram_load_dump_seq with a behavioural falling-edge RAM.
module tb_ram_load_dump_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_load, start_dump;
   logic [3:0] in_data;
   logic       in_valid, in_last, in_ready;
   logic [3:0] out_data;
   logic       out_valid, out_ready;
   logic [6:0] count;
   logic       busy, done;
   logic [3:0] ram_data;
   logic [5:0] ram_addr;
   logic       ram_we_n;
   logic [3:0] ram_q;
`ifdef LOAD_DUMP_CHECKSUM_EN
   logic       chk_err;
`endif

   logic [3:0] mem [64];
   logic [5:0] addr_lat = '0;
   logic [5:0] wr_q [$];
   logic       corrupt_en = 1'b0;
   logic [5:0] corrupt_addr = '0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_load_dump_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_load (start_load),
      .start_dump (start_dump),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .ram_data   (ram_data),
      .ram_addr   (ram_addr),
      .ram_we_n   (ram_we_n),
`ifdef LOAD_DUMP_CHECKSUM_EN
      .chk_err    (chk_err),
`endif
      .ram_q      (ram_q)
   );

   always @(negedge clk) begin
      if (!ram_we_n) begin
         mem[ram_addr] <= ram_data;
         wr_q.push_back(ram_addr);
      end
      addr_lat <= ram_addr;
   end

   assign ram_q = mem[addr_lat] ^ ((corrupt_en && (addr_lat == corrupt_addr)) ? 4'h8 : 4'h0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input logic [3:0] w[$], input bit use_last, input bit both_starts);
      wr_q.delete();
      start_load = 1'b1;
      start_dump = both_starts;
      tick();
      start_load = 1'b0;
      start_dump = 1'b0;
      chk("load_in_ready", in_ready, 1);
      chk("load_count_clr", count, 0);
      for (int i = 0; i < w.size(); i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         in_last  = use_last && (i == w.size() - 1);
         #1;
         chk("load_we_n", ram_we_n, 0);
         tick();
      end
      in_last = 1'b0;
      chk("load_done", done, 1);
      chk("load_count", count, w.size());
      chk("load_in_ready_off", in_ready, 0);
      tick();
      in_valid = 1'b0;
      chk("load_done_pulse", done, 0);
      chk("load_write_cnt", wr_q.size(), w.size());
      for (int i = 0; i < w.size(); i++) begin
         chk("load_addr", wr_q[i], i);
         chk("load_mem", mem[i], w[i]);
      end
   endtask

   task automatic dump_check(input logic [3:0] exp[$], input bit rdy_pat[$], input int exp_cyc);
      int         idx = 0;
      int         cyc = 0;
      bit         saw_done;
      bit         stalled = 1'b0;
      logic [3:0] stall_data = '0;
      out_ready  = rdy_pat[0];
      start_dump = 1'b1;
      tick();
      start_dump = 1'b0;
      chk("dump_lat1_valid", out_valid, 0);
      tick();
      chk("dump_lat2_valid", out_valid, exp.size() > 0);
      saw_done = done;
      while (!saw_done && cyc < 400) begin
         if (stalled)
            chk("dump_stall_hold", out_data, stall_data);
         stalled   = 1'b0;
         out_ready = rdy_pat[cyc % rdy_pat.size()];
         chk("dump_we_n", ram_we_n, 1);
         if (out_valid && out_ready) begin
            chk("dump_word", out_data, exp[idx]);
            idx++;
         end else if (out_valid) begin
            stalled    = 1'b1;
            stall_data = out_data;
         end
         tick();
         saw_done = done;
         cyc++;
      end
      chk("dump_done_seen", saw_done, 1);
      chk("dump_words", idx, exp.size());
      chk("dump_cycles", cyc, exp_cyc);
      chk("dump_end_valid", out_valid, 0);
      chk("dump_end_busy", busy, 0);
   endtask

   initial begin
      logic [3:0] w5[$]  = '{4'h3, 4'h7, 4'hA, 4'h1, 4'hF};
      logic [3:0] w2[$]  = '{4'h5, 4'hC};
      logic [3:0] w64[$];
      logic [3:0] none[$];
      bit         rdy_all[$] = '{1'b1};
      bit         rdy_tog[$] = '{1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 64; i++) begin
         mem[i] = '0;
         w64.push_back(4'(i));
      end
      rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0;
      in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we_n", ram_we_n, 1);
`ifdef LOAD_DUMP_CHECKSUM_EN
      chk("rst_chk_err", chk_err, 0);
`endif
      rst_n = 1'b1;
      tick();

      dump_check(none, rdy_all, 0);
      load_words(w2, 1'b1, 1'b1);
      load_words(w5, 1'b1, 1'b0);
      dump_check(w5, rdy_all, 5);
      dump_check(w5, rdy_tog, 13);
      load_words(w64, 1'b0, 1'b0);
      dump_check(w64, rdy_all, 64);

      out_ready  = 1'b1;
      start_dump = 1'b1;
      tick();
      start_dump = 1'b0;
      tick();
      tick();
      chk("middump_valid_pre", out_valid, 1);
      rst_n = 1'b0;
      tick();
      chk("middump_rst_valid", out_valid, 0);
      chk("middump_rst_busy", busy, 0);
      chk("middump_rst_count", count, 0);
      chk("middump_rst_we_n", ram_we_n, 1);
      chk("middump_rst_data", out_data, 0);
      rst_n = 1'b1;
      tick();

      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      in_valid   = 1'b1;
      in_data    = 4'h9;
      tick();
      in_data = 4'h5;
      rst_n   = 1'b0;
      #1;
      chk("midload_rst_we_n", ram_we_n, 1);
      tick();
      chk("midload_rst_count", count, 0);
      chk("midload_rst_in_ready", in_ready, 0);
      chk("midload_mem0", mem[0], 4'h9);
      chk("midload_mem1", mem[1], 4'h1);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();

`ifdef LOAD_DUMP_CHECKSUM_EN
      begin
         logic [3:0] wc[$]   = '{4'h1, 4'h2, 4'h4};
         logic [3:0] wbad[$] = '{4'h1, 4'hA, 4'h4};
         load_words(wc, 1'b1, 1'b0);
         dump_check(wc, rdy_all, 3);
         chk("chk_err_clean", chk_err, 0);
         corrupt_addr = 6'd1;
         corrupt_en   = 1'b1;
         dump_check(wbad, rdy_all, 3);
         chk("chk_err_corrupt", chk_err, 1);
         corrupt_en = 1'b0;
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
